// File: rtl/controlador_copia_memoria_if.sv
// Data-memory port bundle between the copy controller and the data memory.
//   master : copy controller (drives address, write data and enables)
//   slave  : data memory (returns read data after the falling edge)
// Signals:
//   Endereco     memory address
//   DadoEscrito  write data
//   EscMem       write enable, committed on the rising edge
//   LerMem       read enable, DadoLido valid after the falling edge
//   DadoLido     read data
interface controlador_copia_memoria_if #(
   parameter int LARG_END  = 8,
   parameter int LARG_DADO = 8
);
   logic [LARG_END-1:0]  Endereco;
   logic [LARG_DADO-1:0] DadoEscrito;
   logic [LARG_DADO-1:0] DadoLido;
   logic                 EscMem;
   logic                 LerMem;

   modport master (
      output Endereco, DadoEscrito, EscMem, LerMem,
      input  DadoLido
   );

   modport slave (
      input  Endereco, DadoEscrito, EscMem, LerMem,
      output DadoLido
   );
endinterface

// File: rtl/controlador_copia_memoria.sv
// Byte-run copy engine: reads Quantidade bytes starting at Origem and writes
// them starting at Destino, one read cycle + one write cycle per byte.
// Ports:
//   Clock, Reset_n  clock, asynchronous active-low reset
//   Iniciar         start request, honoured only when idle
//   Origem/Destino  first source / destination address (latched at start)
//   Quantidade      byte count (latched at start, 0 allowed)
//   Ocupado         high during LER/ESCREVER
//   Concluido       one-cycle completion pulse (FIM)
//   mem             data-memory port (master side)
module controlador_copia_memoria #(
   parameter int LARG_END  = 8,
   parameter int LARG_DADO = 8
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                Iniciar,
   input  logic [LARG_END-1:0] Origem,
   input  logic [LARG_END-1:0] Destino,
   input  logic [LARG_END-1:0] Quantidade,
   output logic                Ocupado,
   output logic                Concluido,
   controlador_copia_memoria_if.master mem
);

   typedef enum logic [1:0] {OCIOSO, LER, ESCREVER, FIM} estado_t;

   estado_t              estado;
   logic [LARG_END-1:0]  src, dst, cnt;
   logic [LARG_END-1:0]  endereco;
   logic [LARG_DADO-1:0] dado;

   localparam logic [LARG_END-1:0] UM = LARG_END'(1);

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         estado   <= OCIOSO;
         src      <= '0;
         dst      <= '0;
         cnt      <= '0;
         endereco <= '0;
         dado     <= '0;
      end else begin
         case (estado)
            OCIOSO: if (Iniciar) begin
               src <= Origem;
               dst <= Destino;
               cnt <= Quantidade;
               if (Quantidade == '0) begin
                  estado <= FIM;
               end else begin
                  estado   <= LER;
                  endereco <= Origem;
               end
            end
            LER: begin
               // read data settled on the falling edge; present it for the write
               dado     <= mem.DadoLido;
               endereco <= dst;
               estado   <= ESCREVER;
            end
            ESCREVER: begin
               // memory commits dado to dst on this same edge
               src <= src + UM;
               dst <= dst + UM;
               cnt <= cnt - UM;
               if (cnt == UM) begin
                  estado <= FIM;
               end else begin
                  estado   <= LER;
                  endereco <= src + UM;
               end
            end
            default: estado <= OCIOSO;
         endcase
      end
   end

   // Enables are state decodes so an asynchronous reset drops them at once.
   assign mem.LerMem      = (estado == LER);
   assign mem.EscMem      = (estado == ESCREVER);
   assign mem.Endereco    = endereco;
   assign mem.DadoEscrito = dado;
   assign Ocupado         = (estado == LER) || (estado == ESCREVER);
   assign Concluido       = (estado == FIM);

endmodule

// File: tb/tb_controlador_copia_memoria.sv
// Directed bench for controlador_copia_memoria with a 256-byte memory model
// (write on rising edge, read data returned on falling edge).
module tb_controlador_copia_memoria;
   logic       Clock = 1'b0;
   logic       Reset_n = 1'b0;
   logic       Iniciar = 1'b0;
   logic [7:0] Origem = '0, Destino = '0, Quantidade = '0;
   logic       Ocupado, Concluido;
   logic       carregar = 1'b1;
   logic [7:0] mem [256];

   int total = 0;
   int bad = 0;
   int occ_cnt = 0, con_cnt = 0, esc_cnt = 0, both_cnt = 0;

   controlador_copia_memoria_if #(.LARG_END(8), .LARG_DADO(8)) bus ();

   controlador_copia_memoria #(.LARG_END(8), .LARG_DADO(8)) dut (
      .Clock      (Clock),
      .Reset_n    (Reset_n),
      .Iniciar    (Iniciar),
      .Origem     (Origem),
      .Destino    (Destino),
      .Quantidade (Quantidade),
      .Ocupado    (Ocupado),
      .Concluido  (Concluido),
      .mem        (bus.master)
   );

   always #5 Clock = ~Clock;

   // memory model: preload mem[i]=i+100, otherwise commit writes on the rising edge
   always @(posedge Clock) begin
      if (carregar) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i + 100);
      end else if (bus.EscMem === 1'b1) begin
         mem[bus.Endereco] <= bus.DadoEscrito;
      end
   end

   always @(negedge Clock) begin
      if (bus.LerMem === 1'b1) bus.DadoLido <= mem[bus.Endereco];
   end

   // activity counters sampled on pre-edge values
   always @(posedge Clock) begin
      if (Ocupado === 1'b1) occ_cnt <= occ_cnt + 1;
      if (Concluido === 1'b1) con_cnt <= con_cnt + 1;
      if (bus.EscMem === 1'b1) esc_cnt <= esc_cnt + 1;
      if (bus.EscMem === 1'b1 && bus.LerMem === 1'b1) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic reload();
      carregar = 1'b1;
      @(posedge Clock); #1;
      carregar = 1'b0;
   endtask

   // start a copy and check the timing of Ocupado/Concluido/EscMem
   task automatic run_copy(input string tag, input logic [7:0] o, input logic [7:0] d,
                           input logic [7:0] q);
      int occ0, con0, esc0;
      Origem = o; Destino = d; Quantidade = q; Iniciar = 1'b1;
      occ0 = occ_cnt; con0 = con_cnt; esc0 = esc_cnt;
      @(posedge Clock); #1;              // edge 0
      Iniciar = 1'b0;
      Origem = 8'hAA; Destino = 8'h55; Quantidade = 8'd7;  // free to change after acceptance
      check({tag, "_ocup_e0"}, Ocupado, (q != 0));
      check({tag, "_conc_e0"}, Concluido, (q == 0));
      repeat (2 * int'(q)) begin @(posedge Clock); #1; end
      check({tag, "_conc_fim"}, Concluido, 1'b1);
      check({tag, "_ocup_fim"}, Ocupado, 1'b0);
      @(posedge Clock); #1;
      check({tag, "_conc_off"}, Concluido, 1'b0);
      check({tag, "_ocup_cycles"}, occ_cnt - occ0, 2 * int'(q));
      check({tag, "_conc_pulses"}, con_cnt - con0, 1);
      check({tag, "_writes"}, esc_cnt - esc0, int'(q));
   endtask

   initial begin
      int esc0, con0;
      // reset held 3 cycles with Iniciar toggling
      repeat (3) begin
         @(posedge Clock); #1;
         Iniciar = ~Iniciar;
      end
      check("rst_end", bus.Endereco, 0);
      check("rst_dado", bus.DadoEscrito, 0);
      check("rst_esc", bus.EscMem, 0);
      check("rst_ler", bus.LerMem, 0);
      check("rst_ocup", Ocupado, 0);
      check("rst_conc", Concluido, 0);
      check("rst_writes", esc_cnt, 0);
      Iniciar = 1'b0;
      carregar = 1'b0;
      Reset_n = 1'b1;
      @(posedge Clock); #1;
      check("rst_ocup_after", Ocupado, 0);

      // basic copy, with datapath spot checks in the first byte
      Origem = 8'd0; Destino = 8'd16; Quantidade = 8'd4; Iniciar = 1'b1;
      @(posedge Clock); #1;              // edge 0
      Iniciar = 1'b0;
      check("basic_ler_addr", bus.Endereco, 0);
      check("basic_ler_en", bus.LerMem, 1);
      check("basic_ler_esc", bus.EscMem, 0);
      @(posedge Clock); #1;              // edge 1
      check("basic_esc_addr", bus.Endereco, 16);
      check("basic_esc_data", bus.DadoEscrito, 100);
      check("basic_esc_en", bus.EscMem, 1);
      check("basic_esc_ler", bus.LerMem, 0);
      repeat (6) begin @(posedge Clock); #1; end   // edge 7
      check("basic_conc_e7", Concluido, 0);
      @(posedge Clock); #1;              // edge 8
      check("basic_conc_e8", Concluido, 1);
      @(posedge Clock); #1;
      check("basic_m16", mem[16], 100);
      check("basic_m17", mem[17], 101);
      check("basic_m18", mem[18], 102);
      check("basic_m19", mem[19], 103);
      check("basic_m0", mem[0], 100);
      check("basic_m3", mem[3], 103);
      check("basic_m20", mem[20], 120);
      // full timing check of the same copy after a reload
      reload();
      run_copy("basic", 8'd0, 8'd16, 8'd4);
      check("basic2_m19", mem[19], 103);

      // zero length
      run_copy("zero", 8'd0, 8'd50, 8'd0);
      check("zero_m50", mem[50], 150);

      // wrap-around of the source
      reload();
      run_copy("wrap_src", 8'd254, 8'd10, 8'd3);
      check("wrap_src_m10", mem[10], 98);
      check("wrap_src_m11", mem[11], 99);
      check("wrap_src_m12", mem[12], 100);
      check("wrap_src_m13", mem[13], 113);

      // wrap-around of the destination
      reload();
      run_copy("wrap_dst", 8'd0, 8'd254, 8'd3);
      check("wrap_dst_m254", mem[254], 100);
      check("wrap_dst_m255", mem[255], 101);
      check("wrap_dst_m0", mem[0], 102);
      check("wrap_dst_m1", mem[1], 101);

      // overlapping forward copy propagates the first byte
      reload();
      run_copy("ovl", 8'd0, 8'd1, 8'd3);
      check("ovl_m1", mem[1], 100);
      check("ovl_m2", mem[2], 100);
      check("ovl_m3", mem[3], 100);
      check("ovl_m4", mem[4], 104);

      // busy: Iniciar ignored during LER, then reset mid-copy
      reload();
      esc0 = esc_cnt; con0 = con_cnt;
      Origem = 8'd0; Destino = 8'd32; Quantidade = 8'd6; Iniciar = 1'b1;
      @(posedge Clock); #1;              // edge 0
      Iniciar = 1'b0;
      @(posedge Clock); #1;              // edge 1
      @(posedge Clock); #1;              // edge 2, in LER
      Origem = 8'd100; Destino = 8'd200; Quantidade = 8'd1; Iniciar = 1'b1;
      @(posedge Clock); #1;              // edge 3
      Iniciar = 1'b0;
      check("busy_ocup", Ocupado, 1);
      check("busy_esc_addr", bus.Endereco, 33);
      @(posedge Clock); #3;              // edge 4, then mid-cycle reset
      Reset_n = 1'b0;
      #1;
      check("midrst_esc", bus.EscMem, 0);
      check("midrst_ler", bus.LerMem, 0);
      check("midrst_ocup", Ocupado, 0);
      repeat (2) @(posedge Clock);
      #1;
      Reset_n = 1'b1;
      repeat (20) begin @(posedge Clock); #1; end
      check("midrst_writes", esc_cnt - esc0, 2);
      check("midrst_conc", con_cnt - con0, 0);
      check("midrst_idle", Ocupado, 0);
      check("midrst_m32", mem[32], 100);
      check("midrst_m33", mem[33], 101);
      check("midrst_m34", mem[34], 134);
      check("midrst_m37", mem[37], 137);
      check("busy_m200", mem[200], 44);

      check("never_both_enables", both_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
